ex_muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit in the EX stage, beside the ALU.

---
 rtl/ex_muldiv_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage
// One shared 2*XLEN accumulator serves shift-add multiply and restoring divide.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [2:0]          op;
  logic                sign_a;
  logic                sign_b;
  logic [XLEN-1:0]     mag;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;

  logic                is_div;
  logic                signed_a;
  logic                signed_b;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic                div_zero;
  logic                div_ovf;
  logic                special;
  logic [XLEN-1:0]     special_val;

  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    neg_a    = signed_a & op_a[XLEN-1];
    neg_b    = signed_b & op_b[XLEN-1];
    abs_a    = neg_a ? (~op_a + 1'b1) : op_a;
    abs_b    = neg_b ? (~op_b + 1'b1) : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
    special  = div_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
    if (div_zero)
      special_val = funct3[1] ? op_a : {XLEN{1'b1}};
    else
      special_val = funct3[1] ? '0 : op_a;
  end

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
  end

  // Divide step: upper half is the partial remainder, lower half shifts dividend out and quotient in.
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag};
    if (!div_diff[XLEN])
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo  = (sign_a ^ sign_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem  = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op)
      3'd0:                fix_val = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_val = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_val = quo;
      default:             fix_val = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op     <= funct3;
            sign_a <= neg_a;
            sign_b <= neg_b;
            cnt    <= CW'(XLEN-1);
            if (special) begin
              result <= special_val;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              mag   <= is_div ? abs_b : abs_a;
              acc   <= {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - 1'b1;
        end
        FIX: begin
          result <= fix_val;
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
